// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side streaming block.
// Occupancy encodings are shared by the skid buffer and the top.
package fifo_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream.
// master = the read-stream block, slave = FIFO and sink side.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF
);

  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_val;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output fifo_rd_en,
    output out_valid,
    output out_data,
    input  fifo_rd_data,
    input  fifo_rd_val,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    output fifo_rd_data,
    output fifo_rd_val,
    output out_ready
  );

endinterface

// File: rtl/stream_skid2.sv
// Two-entry head/tail skid buffer with occupancy FSM.
// Head is always the presented beat; tail only fills under stall.
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output occ_e          occ
);

  occ_e          occ_q, occ_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (in_valid) begin
          occ_d  = OCC_ONE;
          head_d = in_data;
        end
      end
      OCC_ONE: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          occ_d  = OCC_FULL;
          tail_d = in_data;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // The read-enable throttle upstream must make this unreachable.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(in_valid && occ_q == OCC_FULL)
  );

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read master: issues rd_en, captures the 1-cycle-late data
// into a 2-entry skid buffer and counts delivered beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drain_en,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 idle
);

  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  occ_e                 occ;
  logic                 pop;
  logic                 cap;
  logic                 rd_en;
  logic [2:0]           level;

  assign pop = skid_valid & bus.out_ready;
  assign cap = pend_q & bus.fifo_rd_val;

  // Count the in-flight read as occupied so a capture always fits.
  always_comb begin
    level = 3'(occ) + 3'(pend_q) - 3'(pop);
    rd_en = ~reset & drain_en & (level < 3'd2);
  end

  always_comb begin
    pend_d = rd_en;
    cnt_d  = cnt_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  stream_skid2 #(
    .DW(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (cap),
    .in_data  (bus.fifo_rd_data),
    .pop      (pop),
    .out_valid(skid_valid),
    .out_data (skid_data),
    .occ      (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = skid_valid;
  assign bus.out_data   = skid_data;
  assign beat_cnt       = cnt_q;
  assign idle           = (occ == OCC_EMPTY) & ~pend_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: FIFO model on the read port, stream sink,
// and a second narrow-counter instance for wrap checking.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  logic reset;
  logic drain;
  logic drain2;
  logic model_rst;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic idle;
  logic idle2;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DW(4)) b ();
  fifo_rd_stream_if #(.DW(4)) b2 ();

  fifo_rd_stream #(
    .DATA_WIDTH(4),
    .CNT_WIDTH (16)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .drain_en(drain),
    .bus     (b.master),
    .beat_cnt(cnt),
    .idle    (idle)
  );

  fifo_rd_stream #(
    .DATA_WIDTH(4),
    .CNT_WIDTH (2)
  ) u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .drain_en(drain2),
    .bus     (b2.master),
    .beat_cnt(cnt2),
    .idle    (idle2)
  );

  logic [3:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (model_rst) begin
      b.fifo_rd_val  <= 1'b0;
      b.fifo_rd_data <= '0;
      rd_ptr         <= 0;
    end else if (b.fifo_rd_en) begin
      if (rd_ptr != wr_ptr) begin
        b.fifo_rd_data <= mem[rd_ptr];
        b.fifo_rd_val  <= 1'b1;
        rd_ptr         <= rd_ptr + 1;
      end else begin
        b.fifo_rd_val  <= 1'b0;
      end
    end
  end

  logic [3:0] d2;
  always @(posedge clk) begin
    if (reset) begin
      b2.fifo_rd_val  <= 1'b0;
      b2.fifo_rd_data <= '0;
      d2              <= 4'd1;
    end else if (b2.fifo_rd_en) begin
      b2.fifo_rd_val  <= 1'b1;
      b2.fifo_rd_data <= d2;
      d2              <= d2 + 4'd1;
    end
  end

  logic [3:0] got [0:127];
  int n_got = 0;
  int max_occ = 0;

  always @(posedge clk) begin
    if (!reset && b.out_valid && b.out_ready) begin
      got[n_got] <= b.out_data;
      n_got      <= n_got + 1;
    end
    if (int'(u_dut.u_skid.occ_q) > max_occ)
      max_occ <= int'(u_dut.u_skid.occ_q);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int t;
    int exp4 [0:3];
    int exp_w [0:4];
    exp4  = '{7, 6, 5, 4};
    exp_w = '{1, 2, 3, 0, 1};

    reset = 1'b1;
    drain = 1'b1;
    drain2 = 1'b0;
    model_rst = 1'b1;
    b.out_ready  = 1'b0;
    b2.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", int'(b.out_valid), 0);
    check("rst_data", int'(b.out_data), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_rden", int'(b.fifo_rd_en), 0);
    reset = 1'b0;
    model_rst = 1'b0;
    drain = 1'b0;
    tick();

    // 1: back-to-back stream
    push(4'd7); push(4'd6); push(4'd5);
    drain = 1'b1;
    b.out_ready = 1'b1;
    tick();
    check("t1_lat_v0", int'(b.out_valid), 0);
    tick();
    check("t1_v1", int'(b.out_valid), 1);
    check("t1_d7", int'(b.out_data), 7);
    tick();
    check("t1_d6", int'(b.out_data), 6);
    tick();
    check("t1_d5", int'(b.out_data), 5);
    tick();
    check("t1_end_v0", int'(b.out_valid), 0);
    tick();
    drain = 1'b0;
    repeat (2) tick();
    check("t1_cnt", int'(cnt), 3);
    check("t1_idle", int'(idle), 1);

    // 2: backpressure
    b.out_ready = 1'b0;
    push(4'd7); push(4'd6); push(4'd5); push(4'd4);
    drain = 1'b1;
    repeat (5) tick();
    check("t2_occ", int'(u_dut.u_skid.occ_q), 2);
    check("t2_rden", int'(b.fifo_rd_en), 0);
    check("t2_valid", int'(b.out_valid), 1);
    check("t2_data", int'(b.out_data), 7);
    base = n_got;
    b.out_ready = 1'b1;
    repeat (10) tick();
    check("t2_nbeats", n_got - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_beat%0d", i), int'(got[base+i]), exp4[i]);
    check("t2_cnt", int'(cnt), 7);
    drain = 1'b0;
    repeat (2) tick();

    // 3: sticky rd_val and empty polling
    base = n_got;
    push(4'd9);
    drain = 1'b1;
    tick();
    drain = 1'b0;
    repeat (6) tick();
    check("t3_one_beat", n_got - base, 1);
    check("t3_data9", int'(got[base]), 9);
    check("t3_cnt", int'(cnt), 8);
    base = n_got;
    bad = 0;
    drain = 1'b1;
    repeat (10) begin
      tick();
      if (b.out_valid) bad++;
    end
    check("t3_poll_valid", bad, 0);
    check("t3_poll_beats", n_got - base, 0);
    check("t3_poll_cnt", int'(cnt), 8);
    drain = 1'b0;
    repeat (2) tick();

    // 4: alternating ready, continuous writes
    base = n_got;
    drain = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b.out_ready = (i % 2 == 0);
      push(4'(i));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      b.out_ready = (i % 2 == 0);
      tick();
    end
    check("t4_nbeats", n_got - base, 12);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (int'(got[base+i]) != i) bad++;
    check("t4_order", bad, 0);
    check("t4_occ_le2", int'(max_occ <= 2), 1);
    check("t4_cnt", int'(cnt), 20);
    drain = 1'b0;
    b.out_ready = 1'b0;
    repeat (2) tick();

    // 5: reset mid-flight
    push(4'd1); push(4'd2); push(4'd3); push(4'd4); push(4'd5);
    drain = 1'b1;
    tick();
    tick();
    check("t5_occ1", int'(u_dut.u_skid.occ_q), 1);
    check("t5_pend1", int'(u_dut.pend_q), 1);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", int'(b.out_valid), 0);
    check("t5_rst_cnt", int'(cnt), 0);
    check("t5_rst_idle", int'(idle), 1);
    reset = 1'b0;
    base = n_got;
    b.out_ready = 1'b1;
    repeat (12) tick();
    check("t5_nbeats", n_got - base, 3);
    check("t5_first", int'(got[base]), 3);
    check("t5_second", int'(got[base+1]), 4);
    check("t5_third", int'(got[base+2]), 5);
    check("t5_cnt", int'(cnt), 3);
    drain = 1'b0;
    repeat (2) tick();

    // 6: narrow counter wrap
    drain2 = 1'b1;
    t = 0;
    while (!b2.out_valid && t < 20) begin
      tick();
      t++;
    end
    check("t6_valid", int'(b2.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_cnt%0d", i), int'(cnt2), exp_w[i]);
    end
    drain2 = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
